// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared constants and state encodings for the cache fill controller
//
// Purpose: single source for block geometry and FSM encodings used by
// cache_fill_fsm and its word counter.
// Ports: none (package).
package cache_fill_fsm_pkg;

  localparam int ADDR_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
  // Byte-offset bits inside one block (16-bit words, so one extra bit).
  localparam int BLOCK_OFF_BITS  = OFF_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// rtl/cache_fill_fsm_word_counter.sv - word index counter with clear, enable and terminal count
//
// Purpose: W-bit up counter used for both the request and the receive index
// of a block fill. Wraps naturally at 2**W.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (wins over inc)
//   inc         increment enable
//   count       current count
//   tc          count is at its terminal value (2**W - 1)
module cache_fill_fsm_word_counter #(
  parameter int W = cache_fill_fsm_pkg::OFF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  // Block size is a power of two, so the last word index is all ones.
  assign tc = &count;

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller streaming one block from main memory
//
// Purpose: on a lookup miss, stall the pipeline, issue one read per word of
// the missing block, write each returned word into the data array and write
// the tag together with the last data word.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   miss_detected      lookup missed this cycle
//   miss_address       byte address of the missing access
//   memory_valid       main memory returns a word this cycle
//   memory_data_in     returned word
//   fsm_busy           pipeline stall request
//   mem_enable         read request to main memory
//   memory_address     read request address (holds after the last request)
//   write_data_array   data array write enable
//   cache_word_offset  word index of the data array write
//   cache_data_out     data array write data
//   write_tag_array    tag/valid array write enable
//   fill_done          one-cycle pulse on fill completion
module cache_fill_fsm #(
  parameter int ADDR_W          = cache_fill_fsm_pkg::ADDR_W,
  parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
  parameter int OFF_W           = cache_fill_fsm_pkg::OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_valid,
  input  logic [15:0]       memory_data_in,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  cache_word_offset,
  output logic [15:0]       cache_data_out,
  output logic              write_tag_array,
  output logic              fill_done
);

  import cache_fill_fsm_pkg::*;

  localparam int                BLK_OFF  = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BLK_OFF) - 1);

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_done_q;
  logic [OFF_W-1:0]  issue_cnt;
  logic [OFF_W-1:0]  recv_cnt;
  logic              issue_tc;
  logic              recv_tc;
  logic              in_fill;
  logic              start_fill;

  assign in_fill    = (state_q == FILL);
  assign start_fill = !in_fill && miss_detected;

  // Stall in the same cycle the miss is seen, before the state register moves.
  assign fsm_busy   = in_fill || miss_detected;

  // The issue counter wraps to 0 after the last word, so a separate flag
  // remembers that all requests of this block have gone out.
  assign mem_enable = in_fill && !issue_done_q;

  // base_q has its block-offset bits cleared, so the OR is a pure
  // concatenation: no carry can ripple into the tag bits.
  assign issue_addr     = base_q | {{(ADDR_W-OFF_W-1){1'b0}}, issue_cnt, 1'b0};
  assign memory_address = mem_enable ? issue_addr : addr_hold_q;

  assign write_data_array  = in_fill && memory_valid;
  assign cache_word_offset = write_data_array ? recv_cnt : '0;
  assign cache_data_out    = write_data_array ? memory_data_in : 16'h0000;

  // Tag goes in last, with the final data word, so an aborted fill leaves
  // the block invalid.
  assign write_tag_array = write_data_array && recv_tc;
  assign fill_done       = write_tag_array;

  cache_fill_fsm_word_counter #(.W(OFF_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .inc   (mem_enable),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  cache_fill_fsm_word_counter #(.W(OFF_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .inc   (write_data_array),
    .count (recv_cnt),
    .tc    (recv_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      addr_hold_q  <= '0;
      issue_done_q <= 1'b0;
    end else begin
      if (start_fill) begin
        state_q      <= FILL;
        base_q       <= miss_address & ~BLK_MASK;
        issue_done_q <= 1'b0;
      end else if (in_fill) begin
        // miss_detected is deliberately not looked at here.
        if (mem_enable && issue_tc) begin
          issue_done_q <= 1'b1;
        end
        if (fill_done) begin
          state_q <= IDLE;
        end
      end
      if (mem_enable) begin
        addr_hold_q <= issue_addr;
      end
    end
  end

endmodule
